// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one output transmitter between N input-port buffers.
// Non-preemptive: the winner keeps the tx until the tx drops sw_gnt.
module tx_arbiter #(
   parameter int          ID        = 0,
   parameter int          SUBID     = 0,
   parameter int unsigned N_PORTS   = 5,
   parameter int unsigned PORT_BITS = 3,
   parameter int unsigned SIZE      = 8,
   parameter int unsigned BUFF_BITS = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_PORTS-1:0]        in_req,
   output logic [N_PORTS-1:0]        in_done,
   input  logic [N_PORTS*SIZE-1:0]   in_data,
   output logic [BUFF_BITS-1:0]      in_addr,
   output logic                      tx_req,
   input  logic                      tx_gnt,
   input  logic [BUFF_BITS-1:0]      tx_addr,
   output logic [SIZE-1:0]           tx_data,
   output logic [PORT_BITS-1:0]      owner,
   output logic                      busy
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_GNT = 2'd1,
      ST_SENDING  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   if (N_PORTS < 2 || N_PORTS > 8 || (1 << PORT_BITS) < N_PORTS || ID < 0 || SUBID < 0)
   begin : g_bad_params
      $error("tx_arbiter %0d.%0d: illegal N_PORTS/PORT_BITS", ID, SUBID);
   end

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_tx_req;
   logic                   w_tx_req_nxt;
   logic [N_PORTS-1:0]     r_in_done;
   logic [N_PORTS-1:0]     w_in_done_nxt;
   logic [PORT_BITS-1:0]   r_owner;
   logic [PORT_BITS-1:0]   w_owner_nxt;
   logic [PORT_BITS-1:0]   r_rr_ptr;
   logic [PORT_BITS-1:0]   w_rr_ptr_nxt;
   logic                   w_found;
   logic [PORT_BITS-1:0]   w_winner;
   int unsigned            w_best_dist;
   int unsigned            w_dist;
   int unsigned            w_rr;
   logic [SIZE-1:0]        w_tx_data;

   // Winner = requesting port at the smallest upward distance from rr_ptr (mod N_PORTS)
   always_comb begin
      w_found     = 1'b0;
      w_winner    = '0;
      w_best_dist = N_PORTS;
      w_dist      = 0;
      w_rr        = 32'(r_rr_ptr);
      for (int unsigned j = 0; j < N_PORTS; j++) begin
         w_dist = (j >= w_rr) ? (j - w_rr) : (j + N_PORTS - w_rr);
         if (in_req[j] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            w_winner    = PORT_BITS'(j);
            w_found     = 1'b1;
         end
      end
   end

   always_comb begin
      w_tx_data = '0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         if (r_owner == PORT_BITS'(k)) begin
            w_tx_data = in_data[k*SIZE +: SIZE];
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_tx_req_nxt  = r_tx_req;
      w_in_done_nxt = '0;
      w_owner_nxt   = r_owner;
      w_rr_ptr_nxt  = r_rr_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_owner_nxt  = w_winner;
               w_tx_req_nxt = 1'b1;
               w_state_nxt  = ST_WAIT_GNT;
            end
         end
         ST_WAIT_GNT: begin
            if (tx_gnt) begin
               w_state_nxt = ST_SENDING;
            end
         end
         ST_SENDING: begin
            if (!tx_gnt) begin
               w_tx_req_nxt = 1'b0;
               for (int unsigned k = 0; k < N_PORTS; k++) begin
                  if (r_owner == PORT_BITS'(k)) begin
                     w_in_done_nxt[k] = 1'b1;
                  end
               end
               if (r_owner == PORT_BITS'(N_PORTS - 1)) begin
                  w_rr_ptr_nxt = '0;
               end else begin
                  w_rr_ptr_nxt = r_owner + PORT_BITS'(1);
               end
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            w_tx_req_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
         end
         default: begin
            w_tx_req_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_tx_req  <= 1'b0;
         r_in_done <= '0;
         r_owner   <= '0;
         r_rr_ptr  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_tx_req  <= w_tx_req_nxt;
         r_in_done <= w_in_done_nxt;
         r_owner   <= w_owner_nxt;
         r_rr_ptr  <= w_rr_ptr_nxt;
      end
   end

   // Buffer address and data pass straight through; owner is stable while tx_req is high
   assign in_addr = tx_addr;
   assign tx_data = w_tx_data;
   assign tx_req  = r_tx_req;
   assign in_done = r_in_done;
   assign owner   = r_owner;
   assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed, table-driven bench for tx_arbiter (5 ports, 8-bit flits, 3-bit buffer address).
`timescale 1ns/1ps
module tb_tx_arbiter;

   localparam int unsigned NP = 5;
   localparam int unsigned SZ = 8;
   localparam int unsigned BB = 3;
   localparam int unsigned PB = 3;

   logic            clk;
   logic            reset;
   logic [NP-1:0]   in_req;
   logic [NP-1:0]   in_done;
   logic [NP*SZ-1:0] in_data;
   logic [BB-1:0]   in_addr;
   logic            tx_req;
   logic            tx_gnt;
   logic [BB-1:0]   tx_addr;
   logic [SZ-1:0]   tx_data;
   logic [PB-1:0]   owner;
   logic            busy;

   tx_arbiter #(
      .ID(0), .SUBID(0), .N_PORTS(NP), .PORT_BITS(PB), .SIZE(SZ), .BUFF_BITS(BB)
   ) dut (
      .clk(clk), .reset(reset), .in_req(in_req), .in_done(in_done),
      .in_data(in_data), .in_addr(in_addr), .tx_req(tx_req), .tx_gnt(tx_gnt),
      .tx_addr(tx_addr), .tx_data(tx_data), .owner(owner), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NP-1:0] req;
      logic          gnt;
      logic          exp_req;
      logic [NP-1:0] exp_done;
      logic [PB-1:0] exp_owner;
      logic          exp_busy;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SZ-1:0] slice_val(input int unsigned k);
      return SZ'(8'h11 * (k + 1));
   endfunction

   task automatic load_base_data();
      for (int unsigned k = 0; k < NP; k++) in_data[k*SZ +: SZ] = slice_val(k);
   endtask

   task automatic add(input logic [NP-1:0] r, input logic g, input logic er,
                      input logic [NP-1:0] ed, input logic [PB-1:0] eo, input logic eb);
      vec_t v;
      v.req = r; v.gnt = g; v.exp_req = er; v.exp_done = ed; v.exp_owner = eo; v.exp_busy = eb;
      vecs.push_back(v);
   endtask

   task automatic chk_outs(input string tag, input logic er, input logic [NP-1:0] ed,
                           input logic [PB-1:0] eo, input logic eb);
      chk({tag, ".tx_req"},  32'(tx_req),  32'(er));
      chk({tag, ".in_done"}, 32'(in_done), 32'(ed));
      chk({tag, ".owner"},   32'(owner),   32'(eo));
      chk({tag, ".busy"},    32'(busy),    32'(eb));
   endtask

   initial begin
      reset   = 1'b0;
      in_req  = '0;
      tx_gnt  = 1'b0;
      tx_addr = '0;
      load_base_data();

      // Reset values
      #2;
      chk_outs("reset", 1'b0, 5'b00000, 3'd0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk_outs("post_reset", 1'b0, 5'b00000, 3'd0, 1'b0);

      // All ports requesting: strict rotation 0,1,2,3,4,0
      in_req = 5'b11111;
      for (int p = 0; p < 6; p++) begin
         int unsigned e;
         e = 32'(p) % NP;
         tx_gnt = 1'b0; tick();
         chk_outs($sformatf("rr%0d.grant", p), 1'b1, 5'b00000, PB'(e), 1'b1);
         chk($sformatf("rr%0d.tx_data", p), 32'(tx_data), 32'(slice_val(e)));
         tx_gnt = 1'b1; tick();
         tx_gnt = 1'b0; tick();
         chk_outs($sformatf("rr%0d.done", p), 1'b0, NP'(1 << e), PB'(e), 1'b1);
         tick();
         chk_outs($sformatf("rr%0d.idle", p), 1'b0, 5'b00000, PB'(e), 1'b0);
      end
      // rr_ptr is now 1

      // Single request to port 2
      add(5'b00100, 1'b0, 1'b1, 5'b00000, 3'd2, 1'b1);
      add(5'b00100, 1'b0, 1'b1, 5'b00000, 3'd2, 1'b1);
      add(5'b00100, 1'b1, 1'b1, 5'b00000, 3'd2, 1'b1);
      add(5'b00100, 1'b1, 1'b1, 5'b00000, 3'd2, 1'b1);
      add(5'b00100, 1'b0, 1'b0, 5'b00100, 3'd2, 1'b1);
      add(5'b00000, 1'b0, 1'b0, 5'b00000, 3'd2, 1'b0);
      add(5'b00000, 1'b0, 1'b0, 5'b00000, 3'd2, 1'b0);
      // Ports 0 and 3: 3, then wrap to 0, then 3
      add(5'b01001, 1'b0, 1'b1, 5'b00000, 3'd3, 1'b1);
      add(5'b01001, 1'b1, 1'b1, 5'b00000, 3'd3, 1'b1);
      add(5'b01001, 1'b0, 1'b0, 5'b01000, 3'd3, 1'b1);
      add(5'b01001, 1'b0, 1'b0, 5'b00000, 3'd3, 1'b0);
      add(5'b01001, 1'b0, 1'b1, 5'b00000, 3'd0, 1'b1);
      add(5'b01001, 1'b1, 1'b1, 5'b00000, 3'd0, 1'b1);
      add(5'b01001, 1'b0, 1'b0, 5'b00001, 3'd0, 1'b1);
      add(5'b01001, 1'b0, 1'b0, 5'b00000, 3'd0, 1'b0);
      add(5'b01001, 1'b0, 1'b1, 5'b00000, 3'd3, 1'b1);
      add(5'b01001, 1'b1, 1'b1, 5'b00000, 3'd3, 1'b1);
      add(5'b01001, 1'b0, 1'b0, 5'b01000, 3'd3, 1'b1);
      add(5'b00000, 1'b0, 1'b0, 5'b00000, 3'd3, 1'b0);
      // Port 1 wins, port 4 arrives late (ignored), port 1 drops request mid-packet
      add(5'b00010, 1'b0, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b10010, 1'b0, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b10010, 1'b1, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b10000, 1'b1, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b10000, 1'b0, 1'b0, 5'b00010, 3'd1, 1'b1);
      add(5'b00000, 1'b0, 1'b0, 5'b00000, 3'd1, 1'b0);
      // Port 1 alone, served back-to-back with two low tx_req cycles between
      add(5'b00010, 1'b0, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b00010, 1'b1, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b00010, 1'b0, 1'b0, 5'b00010, 3'd1, 1'b1);
      add(5'b00010, 1'b0, 1'b0, 5'b00000, 3'd1, 1'b0);
      add(5'b00010, 1'b0, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b00010, 1'b1, 1'b1, 5'b00000, 3'd1, 1'b1);
      add(5'b00000, 1'b0, 1'b0, 5'b00010, 3'd1, 1'b1);
      add(5'b00000, 1'b0, 1'b0, 5'b00000, 3'd1, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         in_req = vecs[i].req;
         tx_gnt = vecs[i].gnt;
         tick();
         chk_outs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_done,
                  vecs[i].exp_owner, vecs[i].exp_busy);
         chk($sformatf("vec%0d.tx_data", i), 32'(tx_data), 32'(slice_val(vecs[i].exp_owner)));
      end
      // rr_ptr is now 2

      // Owner 4 in SENDING: address and data paths are combinational
      in_req = 5'b10000; tx_gnt = 1'b0; tick();
      tx_gnt = 1'b1; tick();
      chk_outs("own4.send", 1'b1, 5'b00000, 3'd4, 1'b1);
      for (int a = 0; a < 8; a++) begin
         tx_addr = BB'(a);
         in_data[4*SZ +: SZ] = SZ'(8'hA0 + a);
         #1;
         chk($sformatf("addr%0d.in_addr", a), 32'(in_addr), 32'(a));
         chk($sformatf("addr%0d.tx_data", a), 32'(tx_data), 32'(8'hA0 + a));
         tick();
      end
      chk("own4.tx_req_held", 32'(tx_req), 32'd1);

      // Asynchronous reset mid-packet
      #2;
      reset = 1'b0;
      #1;
      chk_outs("async_rst", 1'b0, 5'b00000, 3'd0, 1'b0);
      tx_gnt = 1'b0;
      tx_addr = '0;
      load_base_data();
      tick();
      chk_outs("rst_held", 1'b0, 5'b00000, 3'd0, 1'b0);
      reset  = 1'b1;
      in_req = 5'b11110;
      tick();
      chk_outs("restart", 1'b1, 5'b00000, 3'd1, 1'b1);
      chk("restart.tx_data", 32'(tx_data), 32'(slice_val(1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
